jogo_memoria_param: RTL and testbench
=====================================

Name: jogo_memoria_param

Overview:
- Parametrised, self-contained successor of the memory-game top. FSM, sequence RAM, counters, timeout and button edge detection all live in one block.
- Generalised over button count, maximum rounds, demo round count, LED and timeout timing.
- Adds a lives counter: an error with lives remaining replays the round instead of ending the game.
- Sits directly under the board top. The board top keeps the 7-segment decoders and drives them from the db_* ports.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs. Minimum 2. W = clog2(N_BOTOES) is the element code width.
- MAX_RODADAS, 16, rounds in full mode. Equals sequence RAM depth. Minimum 2.
- RODADAS_DEMO, 4, rounds in demo mode. Must satisfy 1 ≤ RODADAS_DEMO ≤ MAX_RODADAS.
- T_LED, 50_000_000, display on-time and off-time per element, in cycles.
- T_TIMEOUT, 250_000_000, cycles allowed per play before a timeout.
- VIDAS, 3, lives at game start. Minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- jogar  in  1  start/restart game (level, sampled each cycle)
- configuracao  in  2  [0] 1 = demo mode, 0 = full mode; [1] 1 = timeout enabled; latched on game start
- botoes  in  N_BOTOES  raw buttons, active-high, already synchronised
- leds  out  N_BOTOES  one-hot element during display, otherwise registered botoes
- pronto  out  1  game finished, any outcome
- ganhou  out  1  all rounds completed
- perdeu  out  1  lost by error with no lives left
- timeout  out  1  lost by timeout
- vidas  out  clog2(VIDAS+1)  lives remaining
- db_estado  out  5  FSM state code
- db_rodada  out  clog2(MAX_RODADAS)  current round index, 0-based
- db_endereco  out  clog2(MAX_RODADAS)  sequence address
- db_jogada  out  W  last registered play code

Behaviour:
- Reset: leds=0, pronto=ganhou=perdeu=timeout=0, vidas=VIDAS, all counters 0, state INICIAL. Reset mid-game aborts with no residue.
- Button capture:
  - botoes is registered every cycle.
  - A play (jogada_feita) is a 1-cycle pulse when the registered value goes from 0 to nonzero.
  - Code = index of the set bit.
  - More than one bit set on that transition is an invalid play and is treated as an error.
  - Further presses are ignored until the buttons return to 0.
- States and codes:
  - INICIAL 0: outputs idle. jogar=1 latches configuracao, sets vidas=VIDAS, zeroes rodada and endereco, goes to NOVO_ELEM.
  - NOVO_ELEM 1: waits for a valid play; writes its code to RAM[rodada]; goes to PREP_MOSTRA. An invalid play is ignored here.
  - PREP_MOSTRA 2: endereco=0, LED counter=0, then MOSTRA.
  - MOSTRA 3: leds = one-hot(RAM[endereco]) for T_LED cycles, then all zero for T_LED cycles. If endereco==rodada go to PREP_ESPERA, else endereco+1 and repeat. Buttons are ignored.
  - PREP_ESPERA 4: endereco=0, timeout counter=0, then ESPERA.
  - ESPERA 5:
    - Valid play: go to COMPARA.
    - Invalid play: go to ERRO.
    - Timeout counter reaches T_TIMEOUT−1 with timeout enabled: go to FIM_TIMEOUT.
    - Counter saturates when timeout is disabled.
  - COMPARA 6:
    - Mismatch: go to ERRO.
    - Match with endereco<rodada: endereco+1, timeout counter=0, back to ESPERA.
    - Match with endereco==rodada: go to PROXIMA.
  - PROXIMA 7:
    - rodada == limit−1 (limit = RODADAS_DEMO or MAX_RODADAS): go to FIM_ACERTO.
    - Otherwise rodada+1, go to NOVO_ELEM.
  - ERRO 8:
    - vidas>1: vidas−1, go to PREP_MOSTRA (replay same round; RAM and rodada unchanged).
    - vidas==1: vidas=0, go to FIM_ERRO.
  - FIM_ACERTO 9: pronto=1, ganhou=1.
  - FIM_ERRO 10: pronto=1, perdeu=1.
  - FIM_TIMEOUT 11: pronto=1, timeout=1.
- Terminal states: outputs are held until jogar=1, which clears the flags and restarts exactly as from INICIAL.
- jogar is ignored in all non-terminal states except INICIAL.
- Counters: rodada and endereco never wrap. The LED counter and timeout counter are sized to their parameter.
- Outputs are registered or decoded from state. Each flag is asserted 1 cycle after the terminal state is entered.

Optional Feature:
- Macro: LFSR_SEQ_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) free-runs every cycle.
  - NOVO_ELEM does not wait for a play. It writes lfsr[W-1:0] mod N_BOTOES to RAM[rodada] in one cycle and proceeds.
- Undefined: new elements are chosen by the player as described above.

Test Plan (N_BOTOES=4, MAX_RODADAS=16, RODADAS_DEMO=4, T_LED=4, T_TIMEOUT=20, VIDAS=2):
- Demo win: jogar with configuracao=01. Enter and repeat the sequence 2,0,3,1 correctly → FIM_ACERTO, ganhou=1, pronto=1, vidas=2, db_rodada=3.
- Display timing: after the first element 2 is entered, leds=4'b0100 for exactly 4 cycles, then 4'b0000 for 4 cycles, then state ESPERA.
- Lives: in round 1 with stored sequence 2,0, press 1 → vidas=1, sequence replayed. Press 3 → FIM_ERRO, perdeu=1, vidas=0.
- Timeout: configuracao=11, no press in ESPERA for 20 cycles → timeout=1, pronto=1, perdeu=0. With configuracao=01, the same wait stays in ESPERA indefinitely.
- Invalid play and hold:
  - Press 4'b0011 in ESPERA → treated as an error, vidas decremented.
  - Holding a button across 10 cycles registers exactly one play.
- Reset and restart:
  - Assert reset mid-MOSTRA → all outputs 0, vidas=2, state INICIAL immediately (asynchronous).
  - jogar in FIM_ERRO restarts with flags cleared.

Source files
------------

// File: rtl/jogo_memoria_param.sv
// Parametrised memory game: FSM, sequence RAM, LED/timeout counters and button capture in one block.
// Build option LFSR_SEQ_EN: new sequence elements come from a free-running LFSR instead of the player.
module jogo_memoria_param #(
    parameter int N_BOTOES     = 4,
    parameter int MAX_RODADAS  = 16,
    parameter int RODADAS_DEMO = 4,
    parameter int T_LED        = 50_000_000,
    parameter int T_TIMEOUT    = 250_000_000,
    parameter int VIDAS        = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           jogar,
    input  logic [1:0]                     configuracao,
    input  logic [N_BOTOES-1:0]            botoes,
    output logic [N_BOTOES-1:0]            leds,
    output logic                           pronto,
    output logic                           ganhou,
    output logic                           perdeu,
    output logic                           timeout,
    output logic [$clog2(VIDAS+1)-1:0]     vidas,
    output logic [4:0]                     db_estado,
    output logic [$clog2(MAX_RODADAS)-1:0] db_rodada,
    output logic [$clog2(MAX_RODADAS)-1:0] db_endereco,
    output logic [$clog2(N_BOTOES)-1:0]    db_jogada
);
    localparam int W  = $clog2(N_BOTOES);
    localparam int RW = $clog2(MAX_RODADAS);
    localparam int VW = $clog2(VIDAS + 1);
    localparam int LW = (T_LED > 1) ? $clog2(T_LED) : 1;
    localparam int TW = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;

    localparam logic [4:0] INICIAL     = 5'd0;
    localparam logic [4:0] NOVO_ELEM   = 5'd1;
    localparam logic [4:0] PREP_MOSTRA = 5'd2;
    localparam logic [4:0] MOSTRA      = 5'd3;
    localparam logic [4:0] PREP_ESPERA = 5'd4;
    localparam logic [4:0] ESPERA      = 5'd5;
    localparam logic [4:0] COMPARA     = 5'd6;
    localparam logic [4:0] PROXIMA     = 5'd7;
    localparam logic [4:0] ERRO        = 5'd8;
    localparam logic [4:0] FIM_ACERTO  = 5'd9;
    localparam logic [4:0] FIM_ERRO    = 5'd10;
    localparam logic [4:0] FIM_TIMEOUT = 5'd11;

    localparam logic [LW-1:0]       LED_MAX  = LW'(T_LED - 1);
    localparam logic [LW-1:0]       L_UM     = LW'(1);
    localparam logic [TW-1:0]       TMO_MAX  = TW'(T_TIMEOUT - 1);
    localparam logic [TW-1:0]       T_UM     = TW'(1);
    localparam logic [RW-1:0]       R_UM     = RW'(1);
    localparam logic [RW-1:0]       LIM_DEMO = RW'(RODADAS_DEMO - 1);
    localparam logic [RW-1:0]       LIM_FULL = RW'(MAX_RODADAS - 1);
    localparam logic [VW-1:0]       V_UM     = VW'(1);
    localparam logic [VW-1:0]       V_INI    = VW'(VIDAS);
    localparam logic [N_BOTOES-1:0] B_UM     = {{(N_BOTOES-1){1'b0}}, 1'b1};

    logic [4:0]          r_estado;
    logic [RW-1:0]       r_rodada;
    logic [RW-1:0]       r_endereco;
    logic [VW-1:0]       r_vidas;
    logic                r_demo;
    logic                r_tmo_en;
    logic [LW-1:0]       r_led_cnt;
    logic                r_fase;
    logic [TW-1:0]       r_tmo_cnt;
    logic [W-1:0]        r_mem [0:MAX_RODADAS-1];
    logic [N_BOTOES-1:0] r_botoes;
    logic [N_BOTOES-1:0] r_botoes_d;
    logic [W-1:0]        r_jogada;
    logic                r_pronto;
    logic                r_ganhou;
    logic                r_perdeu;
    logic                r_timeout;

    logic                w_jogada_feita;
    logic                w_um_bit;
    logic                w_jogada_valida;
    logic                w_jogada_invalida;
    logic [W-1:0]        w_codigo;
    logic [W-1:0]        w_elem;
    logic [N_BOTOES-1:0] w_onehot;
    logic                w_ultima;

    // A play is the first cycle the registered buttons leave zero; two or more bits make it invalid.
    assign w_jogada_feita    = (|r_botoes) & ~(|r_botoes_d);
    assign w_um_bit          = ((r_botoes & (r_botoes - B_UM)) == '0);
    assign w_jogada_valida   = w_jogada_feita & w_um_bit;
    assign w_jogada_invalida = w_jogada_feita & ~w_um_bit;

    always_comb begin
        w_codigo = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (r_botoes[i]) w_codigo = W'(i);
        end
    end

    assign w_elem   = r_mem[r_endereco];
    assign w_onehot = B_UM << w_elem;
    assign w_ultima = r_demo ? (r_rodada == LIM_DEMO) : (r_rodada == LIM_FULL);

`ifdef LFSR_SEQ_EN
    logic [15:0]  r_lfsr;
    logic [W-1:0] w_lfsr_bits;
    logic [W-1:0] w_lfsr_codigo;

    assign w_lfsr_bits   = r_lfsr[W-1:0];
    assign w_lfsr_codigo = (32'(w_lfsr_bits) >= N_BOTOES) ? (w_lfsr_bits - W'(N_BOTOES)) : w_lfsr_bits;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_rodada   <= '0;
            r_endereco <= '0;
            r_vidas    <= V_INI;
            r_demo     <= 1'b0;
            r_tmo_en   <= 1'b0;
            r_led_cnt  <= '0;
            r_fase     <= 1'b0;
            r_tmo_cnt  <= '0;
            r_botoes   <= '0;
            r_botoes_d <= '0;
            r_jogada   <= '0;
            r_pronto   <= 1'b0;
            r_ganhou   <= 1'b0;
            r_perdeu   <= 1'b0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < MAX_RODADAS; i++) r_mem[i] <= '0;
        end else begin
            r_botoes   <= botoes;
            r_botoes_d <= r_botoes;
            if (w_jogada_valida) r_jogada <= w_codigo;

            // Flags follow the terminal state one cycle late and drop on the restarting edge.
            r_ganhou  <= (r_estado == FIM_ACERTO) && !jogar;
            r_perdeu  <= (r_estado == FIM_ERRO) && !jogar;
            r_timeout <= (r_estado == FIM_TIMEOUT) && !jogar;
            r_pronto  <= ((r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO) ||
                          (r_estado == FIM_TIMEOUT)) && !jogar;

            case (r_estado)
                INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (jogar) begin
                        r_demo     <= configuracao[0];
                        r_tmo_en   <= configuracao[1];
                        r_vidas    <= V_INI;
                        r_rodada   <= '0;
                        r_endereco <= '0;
                        r_estado   <= NOVO_ELEM;
                    end
                end
                NOVO_ELEM: begin
`ifdef LFSR_SEQ_EN
                    r_mem[r_rodada] <= w_lfsr_codigo;
                    r_estado        <= PREP_MOSTRA;
`else
                    if (w_jogada_valida) begin
                        r_mem[r_rodada] <= w_codigo;
                        r_estado        <= PREP_MOSTRA;
                    end
`endif
                end
                PREP_MOSTRA: begin
                    r_endereco <= '0;
                    r_led_cnt  <= '0;
                    r_fase     <= 1'b0;
                    r_estado   <= MOSTRA;
                end
                MOSTRA: begin
                    // r_fase 0 = element lit, 1 = dark gap before the next element.
                    if (r_led_cnt == LED_MAX) begin
                        r_led_cnt <= '0;
                        r_fase    <= ~r_fase;
                        if (r_fase) begin
                            if (r_endereco == r_rodada) r_estado <= PREP_ESPERA;
                            else                        r_endereco <= r_endereco + R_UM;
                        end
                    end else begin
                        r_led_cnt <= r_led_cnt + L_UM;
                    end
                end
                PREP_ESPERA: begin
                    r_endereco <= '0;
                    r_tmo_cnt  <= '0;
                    r_estado   <= ESPERA;
                end
                ESPERA: begin
                    if (w_jogada_valida)        r_estado <= COMPARA;
                    else if (w_jogada_invalida) r_estado <= ERRO;
                    else if (r_tmo_cnt == TMO_MAX) begin
                        if (r_tmo_en) r_estado <= FIM_TIMEOUT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + T_UM;
                    end
                end
                COMPARA: begin
                    if (r_jogada != w_elem) r_estado <= ERRO;
                    else if (r_endereco != r_rodada) begin
                        r_endereco <= r_endereco + R_UM;
                        r_tmo_cnt  <= '0;
                        r_estado   <= ESPERA;
                    end else begin
                        r_estado <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    if (w_ultima) r_estado <= FIM_ACERTO;
                    else begin
                        r_rodada <= r_rodada + R_UM;
                        r_estado <= NOVO_ELEM;
                    end
                end
                ERRO: begin
                    if (r_vidas > V_UM) begin
                        r_vidas  <= r_vidas - V_UM;
                        r_estado <= PREP_MOSTRA;
                    end else begin
                        r_vidas  <= '0;
                        r_estado <= FIM_ERRO;
                    end
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign leds        = (r_estado == MOSTRA) ? (r_fase ? '0 : w_onehot) : r_botoes;
    assign pronto      = r_pronto;
    assign ganhou      = r_ganhou;
    assign perdeu      = r_perdeu;
    assign timeout     = r_timeout;
    assign vidas       = r_vidas;
    assign db_estado   = r_estado;
    assign db_rodada   = r_rodada;
    assign db_endereco = r_endereco;
    assign db_jogada   = r_jogada;
endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: table-driven plays, scoreboard of compared play codes, corner sequences.
module tb_jogo_memoria_param;
    localparam logic [4:0] S_INI     = 5'd0;
    localparam logic [4:0] S_NOVO    = 5'd1;
    localparam logic [4:0] S_PREPM   = 5'd2;
    localparam logic [4:0] S_MOSTRA  = 5'd3;
    localparam logic [4:0] S_PREPE   = 5'd4;
    localparam logic [4:0] S_ESPERA  = 5'd5;
    localparam logic [4:0] S_COMPARA = 5'd6;
    localparam logic [4:0] S_FIMA    = 5'd9;
    localparam logic [4:0] S_FIME    = 5'd10;
    localparam logic [4:0] S_FIMT    = 5'd11;

    typedef struct {
        logic [3:0] btn;
        logic [4:0] st_wait;
        logic [4:0] st_after;
        logic [1:0] vidas_after;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [1:0] configuracao;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [1:0] vidas;
    logic [4:0] db_estado;
    logic [3:0] db_rodada;
    logic [3:0] db_endereco;
    logic [1:0] db_jogada;

    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e_jog;
    vec_t       win_tab[14];

    jogo_memoria_param #(
        .N_BOTOES(4), .MAX_RODADAS(16), .RODADAS_DEMO(4),
        .T_LED(4), .T_TIMEOUT(20), .VIDAS(2)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
        .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .vidas(vidas), .db_estado(db_estado),
        .db_rodada(db_rodada), .db_endereco(db_endereco), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required run to end earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [3:0] b);
        logic [1:0] c = 2'd0;
        for (int i = 0; i < 4; i++) if (b[i]) c = 2'(i);
        return c;
    endfunction

    function automatic vec_t mk(input logic [3:0] b, input logic [4:0] sw, input logic [4:0] sa,
                                input logic [1:0] v);
        vec_t r;
        r.btn = b; r.st_wait = sw; r.st_after = sa; r.vidas_after = v;
        return r;
    endfunction

    // Scoreboard: every COMPARA cycle consumes one expected play code.
    always @(negedge clock) begin
        if (!reset && db_estado == S_COMPARA) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_play: got compare of code %0d, required no compare", db_jogada);
            end else begin
                e_jog = exp_q.pop_front();
                check("jogada", 32'(db_jogada), 32'(e_jog));
            end
        end
    end

    task automatic wait_state(input logic [4:0] s, input string name);
        int n = 0;
        while (db_estado !== s && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(db_estado), 32'(s));
    endtask

    task automatic start(input logic [1:0] cfg);
        configuracao = cfg;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        check("start_state", 32'(db_estado), 32'(S_NOVO));
    endtask

    task automatic apply(input vec_t v, input string name);
        wait_state(v.st_wait, {name, "_wait"});
        if (v.st_wait == S_ESPERA && $onehot(v.btn)) exp_q.push_back(code_of(v.btn));
        botoes = v.btn;
        @(negedge clock);
        botoes = 4'b0000;
        repeat (3) @(negedge clock);
        check({name, "_state"}, 32'(db_estado), 32'(v.st_after));
        check({name, "_vidas"}, 32'(vidas), 32'(v.vidas_after));
    endtask

    initial begin
        int n;
        // Demo game with sequence 2,0,3,1 entered and repeated correctly.
        win_tab[0]  = mk(4'b0100, S_NOVO,   S_MOSTRA, 2'd2);
        win_tab[1]  = mk(4'b0100, S_ESPERA, S_NOVO,   2'd2);
        win_tab[2]  = mk(4'b0001, S_NOVO,   S_MOSTRA, 2'd2);
        win_tab[3]  = mk(4'b0100, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[4]  = mk(4'b0001, S_ESPERA, S_NOVO,   2'd2);
        win_tab[5]  = mk(4'b1000, S_NOVO,   S_MOSTRA, 2'd2);
        win_tab[6]  = mk(4'b0100, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[7]  = mk(4'b0001, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[8]  = mk(4'b1000, S_ESPERA, S_NOVO,   2'd2);
        win_tab[9]  = mk(4'b0010, S_NOVO,   S_MOSTRA, 2'd2);
        win_tab[10] = mk(4'b0100, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[11] = mk(4'b0001, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[12] = mk(4'b1000, S_ESPERA, S_ESPERA, 2'd2);
        win_tab[13] = mk(4'b0010, S_ESPERA, S_FIMA,   2'd2);

        reset = 1'b1; jogar = 1'b0; configuracao = 2'b00; botoes = 4'b0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_state", 32'(db_estado), 32'(S_INI));
        check("rst_vidas", 32'(vidas), 32'd2);
        check("rst_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_rodada", 32'(db_rodada), 32'd0);

        start(2'b01);
        for (int i = 0; i < 14; i++) apply(win_tab[i], $sformatf("win%0d", i));
        @(negedge clock);
        check("win_ganhou", 32'(ganhou), 32'd1);
        check("win_pronto", 32'(pronto), 32'd1);
        check("win_perdeu", 32'(perdeu), 32'd0);
        check("win_vidas", 32'(vidas), 32'd2);
        check("win_rodada", 32'(db_rodada), 32'd3);

        // Restart from FIM_ACERTO, then display timing of the first element.
        start(2'b01);
        check("restart_ganhou", 32'(ganhou), 32'd0);
        botoes = 4'b0100;
        @(negedge clock);
        botoes = 4'b0000;
        wait_state(S_MOSTRA, "disp_enter");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("disp_leds%0d", i), 32'(leds), (i < 4) ? 32'd4 : 32'd0);
            @(negedge clock);
        end
        check("disp_prep", 32'(db_estado), 32'(S_PREPE));
        @(negedge clock);
        check("disp_espera", 32'(db_estado), 32'(S_ESPERA));

        // Lives: wrong play in round 1 replays, second wrong play ends the game.
        apply(mk(4'b0100, S_ESPERA, S_NOVO,   2'd2), "liv_a");
        apply(mk(4'b0001, S_NOVO,   S_MOSTRA, 2'd2), "liv_b");
        apply(mk(4'b0010, S_ESPERA, S_PREPM,  2'd1), "liv_err1");
        apply(mk(4'b1000, S_ESPERA, S_FIME,   2'd0), "liv_err2");
        @(negedge clock);
        check("lost_perdeu", 32'(perdeu), 32'd1);
        check("lost_pronto", 32'(pronto), 32'd1);
        check("lost_ganhou", 32'(ganhou), 32'd0);

        start(2'b01);
        check("rs_perdeu", 32'(perdeu), 32'd0);
        check("rs_pronto", 32'(pronto), 32'd0);
        check("rs_vidas", 32'(vidas), 32'd2);
        check("rs_rodada", 32'(db_rodada), 32'd0);

        // Invalid plays: ignored in NOVO_ELEM, an error in ESPERA.
        apply(mk(4'b0011, S_NOVO,   S_NOVO,   2'd2), "inv_novo");
        apply(mk(4'b0010, S_NOVO,   S_MOSTRA, 2'd2), "inv_b");
        apply(mk(4'b0011, S_ESPERA, S_MOSTRA, 2'd1), "inv_espera");
        apply(mk(4'b0010, S_ESPERA, S_NOVO,   2'd1), "inv_replay");
        apply(mk(4'b1000, S_NOVO,   S_MOSTRA, 2'd1), "hold_new");

        // A button held for 10 cycles counts once.
        wait_state(S_ESPERA, "hold_wait");
        exp_q.push_back(2'd1);
        botoes = 4'b0010;
        repeat (10) @(negedge clock);
        botoes = 4'b0000;
        repeat (4) @(negedge clock);
        check("hold_state", 32'(db_estado), 32'(S_ESPERA));
        check("hold_endereco", 32'(db_endereco), 32'd1);
        apply(mk(4'b1000, S_ESPERA, S_NOVO, 2'd1), "hold_end");

        // Timeout enabled: exactly 20 cycles in ESPERA.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start(2'b11);
        apply(mk(4'b0100, S_NOVO, S_MOSTRA, 2'd2), "tmo_new");
        wait_state(S_ESPERA, "tmo_wait");
        n = 0;
        while (db_estado == S_ESPERA && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("tmo_cycles", 32'(n), 32'd20);
        check("tmo_state", 32'(db_estado), 32'(S_FIMT));
        @(negedge clock);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_pronto", 32'(pronto), 32'd1);
        check("tmo_perdeu", 32'(perdeu), 32'd0);

        // Timeout disabled: waits indefinitely.
        start(2'b01);
        check("notmo_flag_clr", 32'(timeout), 32'd0);
        apply(mk(4'b0100, S_NOVO, S_MOSTRA, 2'd2), "notmo_new");
        wait_state(S_ESPERA, "notmo_wait");
        repeat (60) @(negedge clock);
        check("notmo_state", 32'(db_estado), 32'(S_ESPERA));
        check("notmo_flag", 32'(timeout), 32'd0);

        // Asynchronous reset in the middle of MOSTRA.
        apply(mk(4'b0100, S_ESPERA, S_NOVO,   2'd2), "ar_a");
        apply(mk(4'b0001, S_NOVO,   S_MOSTRA, 2'd2), "ar_b");
        check("ar_leds_before", 32'(leds), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("ar_state", 32'(db_estado), 32'(S_INI));
        check("ar_leds", 32'(leds), 32'd0);
        check("ar_vidas", 32'(vidas), 32'd2);
        check("ar_rodada", 32'(db_rodada), 32'd0);
        check("ar_endereco", 32'(db_endereco), 32'd0);
        check("ar_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
